serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer. Time-shares one structural NAND-only 1-bit add cell across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake.
- Sits between a register-file or bus client and the NAND-primitive arithmetic cells. Used where area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_serial_add_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one NAND-only full-add cell time-shared LSB first over WIDTH bits.
// Optional subtract mode is enabled by defining SERADD_SUB_EN (adds the 'sub' input port).
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               b_in, n1, n2, n3, s1, m1, m2, m3, s_bit, c_next;

`ifdef SERADD_SUB_EN
  logic sub_q;
  logic x1, x2, x3;
  // NAND XOR: sub_q=1 inverts the B bit, sub_q=0 passes it through.
  nand u_x1 (x1, b_sh_q[0], sub_q);
  nand u_x2 (x2, b_sh_q[0], x1);
  nand u_x3 (x3, sub_q, x1);
  nand u_x4 (b_in, x2, x3);
`else
  assign b_in = b_sh_q[0];
`endif

  // First half adder: s1 = a ^ b, n1 = ~(a & b).
  nand u_n1 (n1, a_sh_q[0], b_in);
  nand u_n2 (n2, a_sh_q[0], n1);
  nand u_n3 (n3, b_in, n1);
  nand u_n4 (s1, n2, n3);
  // Second half adder: s_bit = s1 ^ c, m1 = ~(s1 & c).
  nand u_m1 (m1, s1, carry_q);
  nand u_m2 (m2, s1, m1);
  nand u_m3 (m3, carry_q, m1);
  nand u_m4 (s_bit, m2, m3);
  // OR of the two half-adder carries, taken from their inverted forms.
  nand u_co (c_next, n1, m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
`ifdef SERADD_SUB_EN
      sub_q    <= 1'b0;
`endif
      sum      <= '0;
      cout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q <= a;
            b_sh_q <= b;
            cnt_q  <= '0;
            busy   <= 1'b1;
`ifdef SERADD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub | cin & ~sub;
`else
            carry_q <= cin;
`endif
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          res_sh_q <= {s_bit, res_sh_q[WIDTH-1:1]};
          carry_q  <= c_next;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum     <= {s_bit, res_sh_q[WIDTH-1:1]};
            cout    <= c_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: expected results queued at start, compared at done.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef SERADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERADD_SUB_EN
    .sub   (sub),
`endif
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [8:0]  held = '0;
  logic [8:0]  sb_q[$];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts, input bit inj);
    logic [8:0] exp_v;
    logic [8:0] got_exp;
    int n;
    int d0;
    if (ts) exp_v = {1'b0, ta} + {1'b0, ~tb} + 9'd1;
    else    exp_v = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    d0 = done_cnt;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
`ifdef SERADD_SUB_EN
    sub = ts;
`endif
    sb_q.push_back(exp_v);
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("result_held", {23'd0, cout, sum}, {23'd0, held});
    n = 0;
    while (done !== 1'b1 && n < 4 * WIDTH) begin
      @(posedge clk); #1;
      n++;
      start = (inj && n == 3);
      if (inj && n == 3) begin a = 8'hFF; b = 8'hFF; end
      if (n == WIDTH - 1) check("busy_mid_run", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    check("done_latency", n, WIDTH);
    got_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
    check("result", {23'd0, cout, sum}, {23'd0, got_exp});
    check("busy_at_done", {31'd0, busy}, 32'd0);
    held = got_exp;
    if (inj) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse_count", done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

    // Abort a run with asynchronous reset partway through.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    held = '0;

    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef SERADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    do_op(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
